// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: default geometry, limits and state encoding for the FFT frame sequencer.
package fft_seq_pkg;
  localparam int I_BW = 14;
  localparam int FRAME_LEN = 2048;
  localparam int GROUP_SIZE = 1024;
  localparam int GNUM_W = 7;
  localparam int GIDX_W = 10;
  localparam int MAX_INFLIGHT = 2;
  localparam int TIMEOUT = 4096;
  localparam int GROUPS_PER_FRAME = FRAME_LEN / GROUP_SIZE;
  typedef enum logic {IDLE, LOAD} state_t;
endpackage

// File: rtl/frame_index_counter.sv
// frame_index_counter: group number / in-group index counter over one frame.
// Ports: clk, rst (async, active-low), inc (advance one sample), clear (sync clear),
//        num/idx (current position), last (position is the final sample of a frame).
module frame_index_counter #(
  parameter int GNUM_W = 7,
  parameter int GIDX_W = 10,
  parameter int GROUPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clear,
  output logic [GNUM_W-1:0] num,
  output logic [GIDX_W-1:0] idx,
  output logic              last
);
  // GROUP_SIZE is 2**GIDX_W, so an all-ones index is the end of a group.
  assign last = num == GNUM_W'(GROUPS - 1) && &idx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      num <= '0;
      idx <= '0;
    end else if (clear || (inc && last)) begin
      num <= '0;
      idx <= '0;
    end else if (inc) begin
      idx <= idx + GIDX_W'(1);
      if (&idx) num <= num + GNUM_W'(1);
    end
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames a sample stream for the bit-reversal stage and retires its output.
// Ports: clk, rst (async, active-low), enable; s_valid/s_data/s_ready upstream stream;
//        di_en/data_i/in_group_num/in_group_idx to the stage; do_en/out_group_num/out_group_idx
//        from the stage; frame_load_done/frame_out_done pulses, inflight, frames_done, seq_err.
module fft_frame_sequencer #(
  parameter int I_BW = fft_seq_pkg::I_BW,
  parameter int FRAME_LEN = fft_seq_pkg::FRAME_LEN,
  parameter int GROUP_SIZE = fft_seq_pkg::GROUP_SIZE,
  parameter int GNUM_W = fft_seq_pkg::GNUM_W,
  parameter int GIDX_W = fft_seq_pkg::GIDX_W,
  parameter int MAX_INFLIGHT = fft_seq_pkg::MAX_INFLIGHT,
  parameter int TIMEOUT = fft_seq_pkg::TIMEOUT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  s_valid,
  input  logic [I_BW-1:0]                       s_data,
  output logic                                  s_ready,
  output logic                                  di_en,
  output logic [I_BW-1:0]                       data_i,
  output logic [GNUM_W-1:0]                     in_group_num,
  output logic [GIDX_W-1:0]                     in_group_idx,
  input  logic                                  do_en,
  input  logic [GNUM_W-1:0]                     out_group_num,
  input  logic [GIDX_W-1:0]                     out_group_idx,
  output logic                                  frame_load_done,
  output logic                                  frame_out_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic [15:0]                           frames_done,
  output logic [1:0]                            seq_err
);
  import fft_seq_pkg::*;
  localparam int GROUPS = FRAME_LEN / GROUP_SIZE;
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  state_t state;
  logic [GNUM_W-1:0] in_num, out_num;
  logic [GIDX_W-1:0] in_idx, out_idx;
  logic in_last, out_last, accept, beat, ld, od, range_bad;
  logic [WD_W-1:0] wd;
  logic unused;
  assign s_ready = state == LOAD;
  assign accept = s_valid && s_ready;
  // Beats with nothing in flight are faults and must not advance the output counter.
  assign beat = do_en && inflight != '0;
  assign ld = accept && in_last;
  assign od = beat && out_last;
  assign range_bad = int'(out_group_num) >= GROUPS || int'(out_group_idx) >= GROUP_SIZE;
  // Only the output counter's end-of-frame flag matters; its position is not needed.
  assign unused = ^{out_num, out_idx};
  frame_index_counter #(.GNUM_W(GNUM_W), .GIDX_W(GIDX_W), .GROUPS(GROUPS)) u_in_cnt (
    .clk(clk), .rst(rst), .inc(accept), .clear(1'b0), .num(in_num), .idx(in_idx), .last(in_last)
  );
  frame_index_counter #(.GNUM_W(GNUM_W), .GIDX_W(GIDX_W), .GROUPS(GROUPS)) u_out_cnt (
    .clk(clk), .rst(rst), .inc(beat), .clear(1'b0), .num(out_num), .idx(out_idx), .last(out_last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      di_en <= 1'b0;
      data_i <= '0;
      in_group_num <= '0;
      in_group_idx <= '0;
      frame_load_done <= 1'b0;
      frame_out_done <= 1'b0;
      inflight <= '0;
      frames_done <= '0;
      seq_err <= '0;
      wd <= '0;
    end else begin
      // Returning to IDLE after the last sample creates the one-cycle inter-frame bubble.
      state <= state == IDLE ? ((enable && inflight < IF_W'(MAX_INFLIGHT)) ? LOAD : IDLE)
                             : (ld ? IDLE : LOAD);
      di_en <= accept;
      if (accept) begin
        data_i <= s_data;
        in_group_num <= in_num;
        in_group_idx <= in_idx;
      end
      frame_load_done <= ld;
      frame_out_done <= od;
      inflight <= inflight + IF_W'(ld) - IF_W'(od);
      if (od) frames_done <= frames_done + 16'd1;
      if (do_en && (inflight == '0 || range_bad)) seq_err[0] <= 1'b1;
      wd <= (do_en || inflight == '0) ? '0 : (wd == WD_W'(TIMEOUT) ? wd : wd + WD_W'(1));
      if (wd == WD_W'(TIMEOUT)) seq_err[1] <= 1'b1;
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized scenarios checked against a sample/beat-counting model.
module tb_fft_frame_sequencer;
  localparam int FL = 2048;
  localparam int GS = 1024;
  logic clk = 0, rst = 0, enable = 0, s_valid = 0, do_en = 0;
  logic [13:0] s_data = '0;
  logic [6:0] out_group_num = '0;
  logic [9:0] out_group_idx = '0;
  logic s_ready, di_en, frame_load_done, frame_out_done;
  logic [13:0] data_i;
  logic [6:0] in_group_num;
  logic [9:0] in_group_idx;
  logic [1:0] inflight, seq_err;
  logic [15:0] frames_done;
  int passed = 0, total = 0;
  int k = 0, b = 0, m_inflight = 0, m_frames = 0;
  bit m_err0 = 0, prev_ld = 0, both_seen = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .di_en(di_en), .data_i(data_i), .in_group_num(in_group_num), .in_group_idx(in_group_idx),
    .do_en(do_en), .out_group_num(out_group_num), .out_group_idx(out_group_idx),
    .frame_load_done(frame_load_done), .frame_out_done(frame_out_done), .inflight(inflight),
    .frames_done(frames_done), .seq_err(seq_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; gnum < 0 means a well-formed output group number.
  task automatic cycle(input bit v, input bit d, input int gnum);
    bit acc, beat, ld, od;
    logic [13:0] dat;
    int g;
    total++; if ((m_inflight == 2 || prev_ld) && s_ready !== 1'b0) $display("FAIL s_ready_low got %b want 0", s_ready); else passed++;
    dat = 14'($urandom);
    g = gnum < 0 ? b / GS : gnum;
    s_valid = v; s_data = dat; do_en = d; out_group_num = 7'(g); out_group_idx = 10'(b % GS);
    acc = v && s_ready;
    beat = d && m_inflight > 0;
    ld = acc && k == FL - 1;
    od = beat && b == FL - 1;
    if (d && (m_inflight == 0 || g >= FL / GS)) m_err0 = 1;
    tick();
    total++; if (di_en !== acc) $display("FAIL di_en got %b want %b (k=%0d)", di_en, acc, k); else passed++;
    if (acc) begin
      total++; if (data_i !== dat) $display("FAIL data_i got %h want %h", data_i, dat); else passed++;
      total++; if (in_group_num !== 7'(k / GS) || in_group_idx !== 10'(k % GS))
        $display("FAIL group got %0d/%0d want %0d/%0d", in_group_num, in_group_idx, k / GS, k % GS); else passed++;
    end
    m_inflight = m_inflight + int'(ld) - int'(od);
    if (od) m_frames = (m_frames + 1) % 65536;
    total++; if (frame_load_done !== ld) $display("FAIL frame_load_done got %b want %b", frame_load_done, ld); else passed++;
    total++; if (frame_out_done !== od) $display("FAIL frame_out_done got %b want %b", frame_out_done, od); else passed++;
    total++; if (inflight !== 2'(m_inflight)) $display("FAIL inflight got %0d want %0d", inflight, m_inflight); else passed++;
    total++; if (frames_done !== 16'(m_frames)) $display("FAIL frames_done got %0d want %0d", frames_done, m_frames); else passed++;
    total++; if (seq_err[0] !== m_err0) $display("FAIL seq_err0 got %b want %b", seq_err[0], m_err0); else passed++;
    if (acc) k = (k + 1) % FL;
    if (beat) b = (b + 1) % FL;
    prev_ld = ld;
    if (ld && od) both_seen = 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 0;
    #1;
    total++; if ({s_ready, di_en, data_i, in_group_num, in_group_idx, frame_load_done, frame_out_done, inflight, frames_done, seq_err} !== '0)
      $display("FAIL async_reset outputs got %b/%b/%h/%0d/%0d/%b/%b/%0d/%0d/%b want all 0", s_ready, di_en, data_i,
               in_group_num, in_group_idx, frame_load_done, frame_out_done, inflight, frames_done, seq_err); else passed++;
    s_valid = 0; do_en = 0;
    @(posedge clk);
    #1 rst = 1;
    k = 0; b = 0; m_inflight = 0; m_frames = 0; m_err0 = 0; prev_ld = 0;
  endtask

  task automatic test_reset();
    #12;
    total++; if ({s_ready, di_en, data_i, in_group_num, in_group_idx, frame_load_done, frame_out_done, inflight, frames_done, seq_err} !== '0)
      $display("FAIL reset_state outputs not all zero (inflight=%0d seq_err=%b)", inflight, seq_err); else passed++;
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_stream();
    enable = 1;
    for (int i = 0; i < 6000 && m_inflight < 2; i++) cycle(1, 0, -1);
    total++; if (inflight !== 2'd2) $display("FAIL stream_inflight got %0d want 2", inflight); else passed++;
    for (int i = 0; i < 50; i++) begin
      cycle(1, 0, -1);
      total++; if (s_ready !== 1'b0) $display("FAIL stream_full_ready got %b want 0", s_ready); else passed++;
    end
  endtask

  task automatic test_retire();
    for (int i = 0; i < FL; i++) cycle(0, 1, -1);
    total++; if (frames_done !== 16'd1 || inflight !== 2'd1)
      $display("FAIL retire got frames_done=%0d inflight=%0d want 1/1", frames_done, inflight); else passed++;
    cycle(0, 0, -1);
    total++; if (s_ready !== 1'b1) $display("FAIL retire_reload got s_ready=%b want 1", s_ready); else passed++;
  endtask

  task automatic test_simultaneous();
    both_seen = 0;
    for (int i = 0; i < FL; i++) cycle(1, 1, -1);
    total++; if (!both_seen) $display("FAIL simultaneous got no coincident pulses want both"); else passed++;
    total++; if (inflight !== 2'd1 || frames_done !== 16'd2)
      $display("FAIL simultaneous_counts got inflight=%0d frames_done=%0d want 1/2", inflight, frames_done); else passed++;
  endtask

  task automatic test_sparse();
    bit done = 0;
    for (int i = 0; i < 12000 && !done; i++) begin
      enable = k < 1000;
      cycle($urandom_range(2) == 0, i < FL, -1);
      done = prev_ld;
    end
    total++; if (!done) $display("FAIL sparse_timeout got no frame_load_done want one"); else passed++;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, -1);
      total++; if (s_ready !== 1'b0) $display("FAIL enable_low_idle got s_ready=%b want 0", s_ready); else passed++;
    end
    total++; if (inflight !== 2'd1 || frames_done !== 16'd3)
      $display("FAIL sparse_counts got inflight=%0d frames_done=%0d want 1/3", inflight, frames_done); else passed++;
  endtask

  task automatic test_errors();
    bit done = 0;
    for (int i = 0; i < FL; i++) cycle(0, 1, -1);
    cycle(0, 1, -1);
    total++; if (seq_err !== 2'b01 || frames_done !== 16'd4)
      $display("FAIL underflow got seq_err=%b frames_done=%0d want 01/4", seq_err, frames_done); else passed++;
    do_reset();
    enable = 1;
    for (int i = 0; i < 3000 && !done; i++) begin
      enable = k < 500;
      cycle(1, 0, -1);
      done = prev_ld;
    end
    total++; if (inflight !== 2'd1 || seq_err !== 2'b00)
      $display("FAIL reload got inflight=%0d seq_err=%b want 1/00", inflight, seq_err); else passed++;
    cycle(0, 1, 2);
    total++; if (seq_err !== 2'b01) $display("FAIL range_num got seq_err=%b want 01", seq_err); else passed++;
    for (int i = 0; i < 4000; i++) cycle(0, 0, -1);
    total++; if (seq_err[1] !== 1'b0) $display("FAIL timeout_early got %b want 0", seq_err[1]); else passed++;
    for (int i = 0; i < 200; i++) cycle(0, 0, -1);
    total++; if (seq_err !== 2'b11) $display("FAIL timeout got seq_err=%b want 11", seq_err); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    enable = 1;
    for (int i = 0; i < 1000 && k < 700; i++) cycle(1, 0, -1);
    do_reset();
    for (int i = 0; i < 5 && !seen; i++) begin
      cycle(1, 0, -1);
      seen = di_en;
    end
    total++; if (!seen || in_group_num !== 7'd0 || in_group_idx !== 10'd0)
      $display("FAIL restart got di_en=%b group %0d/%0d want 1 0/0", seen, in_group_num, in_group_idx); else passed++;
    for (int i = 0; i < 100; i++) cycle(1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_retire();
    test_simultaneous();
    test_sparse();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
